// File: rtl/mppt_pkg.sv
// ---------------------------------------------------------------------------
// mppt_pkg
// Shared definitions for the perturb-and-observe MPPT controller:
//   - controller state encoding
//   - default sample, power and duty widths
//   - duty limits, perturbation step and settle time
// ---------------------------------------------------------------------------
package mppt_pkg;

    // Default datapath widths
    localparam int MPPT_DW     = 6;            // V and I sample width
    localparam int MPPT_PW     = 2 * MPPT_DW;  // exact V*I product width
    localparam int MPPT_DUTY_W = 8;            // PWM duty command width

    // Duty behaviour
    localparam int MPPT_DUTY_INIT  = 128;
    localparam int MPPT_DUTY_MIN   = 5;
    localparam int MPPT_DUTY_MAX   = 250;
    localparam int MPPT_STEP       = 2;
    localparam int MPPT_SETTLE_CYC = 3;        // settle counter load, <= 255

    // One perturb-and-observe iteration walks SETTLE -> SAMPLE -> CALC -> DECIDE
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        CALC   = 3'd3,
        DECIDE = 3'd4
    } mppt_state_t;

endpackage : mppt_pkg

// File: rtl/mult_logic.sv
// ---------------------------------------------------------------------------
// mult_logic
// Combinational unsigned multiplier producing the exact V*I power.
// Ports:
//   V : in  [DW-1:0]  voltage sample
//   I : in  [DW-1:0]  current sample
//   P : out [PW-1:0]  unsigned product V*I
// ---------------------------------------------------------------------------
module mult_logic
    import mppt_pkg::*;
#(
    parameter int DW = MPPT_DW,
    parameter int PW = MPPT_PW
) (
    input  logic [DW-1:0] V,
    input  logic [DW-1:0] I,
    output logic [PW-1:0] P
);

    // Both operands are widened first so the product is formed at full width.
    assign P = PW'(V) * PW'(I);

endmodule : mult_logic

// File: rtl/mppt_po_ctrl.sv
// ---------------------------------------------------------------------------
// mppt_po_ctrl
// Perturb-and-observe MPPT controller. Each iteration waits for the converter
// to settle, requests one V/I sample pair, registers the power product and
// steps the duty command towards higher power, saturating at the duty limits.
// Ports:
//   clk          : in   system clock, rising edge
//   rst_n        : in   asynchronous active-low reset
//   en           : in   run enable; low forces IDLE and holds duty/dir/p_out
//   sample_req   : out  high while waiting for a sample pair
//   sample_valid : in   V/I pair valid, honoured only while sample_req=1
//   v_in, i_in   : in   voltage / current samples
//   duty         : out  registered duty command
//   dir          : out  perturbation direction, 1 = increase
//   p_out        : out  power of the last completed iteration
//   upd          : out  one-cycle pulse after each duty update
//   busy         : out  high whenever the controller is not IDLE
// ---------------------------------------------------------------------------
module mppt_po_ctrl
    import mppt_pkg::*;
#(
    parameter int DW         = MPPT_DW,
    parameter int PW         = MPPT_PW,
    parameter int DUTY_W     = MPPT_DUTY_W,
    parameter int DUTY_INIT  = MPPT_DUTY_INIT,
    parameter int DUTY_MIN   = MPPT_DUTY_MIN,
    parameter int DUTY_MAX   = MPPT_DUTY_MAX,
    parameter int STEP       = MPPT_STEP,
    parameter int SETTLE_CYC = MPPT_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              sample_req,
    input  logic              sample_valid,
    input  logic [DW-1:0]     v_in,
    input  logic [DW-1:0]     i_in,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic [PW-1:0]     p_out,
    output logic              upd,
    output logic              busy
);

    // Typed copies of the integer parameters so every comparison is width-exact.
    localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYC);
    localparam logic [DUTY_W-1:0] INIT_D    = DUTY_W'(DUTY_INIT);
    localparam logic [DUTY_W:0]   MIN_W     = (DUTY_W + 1)'(DUTY_MIN);
    localparam logic [DUTY_W:0]   MAX_W     = (DUTY_W + 1)'(DUTY_MAX);
    localparam logic [DUTY_W:0]   STEP_W    = (DUTY_W + 1)'(STEP);

    mppt_state_t       state, state_nx;
    logic [7:0]        cnt;
    logic [DW-1:0]     v_r, i_r;
    logic [PW-1:0]     p_mult;
    logic [PW-1:0]     p_now;
    logic [PW-1:0]     p_prev;
    logic              prev_valid;
    logic [DUTY_W-1:0] duty_q;
    logic              dir_q;
    logic              upd_q;

    // Decision datapath
    logic              dec_dir;
    logic [DUTY_W:0]   tgt_up, tgt_dn;
    logic [DUTY_W-1:0] duty_nx;
    logic              dir_nx;

    mult_logic #(
        .DW (DW),
        .PW (PW)
    ) u_mult (
        .V (v_r),
        .I (i_r),
        .P (p_mult)
    );

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx   = state;
        sample_req = (state == SAMPLE);
        busy       = (state != IDLE);
        if (!en) begin
            // Disabling wins over everything, including a sample on this edge.
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nx = SETTLE;
                SETTLE:  if (cnt == 8'd0) state_nx = SAMPLE;
                SAMPLE:  if (sample_valid) state_nx = CALC;
                CALC:    state_nx = DECIDE;
                DECIDE:  state_nx = SETTLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Perturbation decision and saturating duty step
    // -----------------------------------------------------------------------
    always_comb begin
        dec_dir = dir_q;
        if (prev_valid && (p_now < p_prev)) dec_dir = ~dir_q;

        // One extra bit: the up target cannot wrap and a down underflow
        // shows up as the top bit set (duty itself never reaches that bit).
        tgt_up = {1'b0, duty_q} + STEP_W;
        tgt_dn = {1'b0, duty_q} - STEP_W;

        duty_nx = duty_q;
        dir_nx  = dec_dir;
        if (dec_dir) begin
            if (tgt_up > MAX_W) begin
                duty_nx = MAX_W[DUTY_W-1:0];
                dir_nx  = 1'b0;
            end else begin
                duty_nx = tgt_up[DUTY_W-1:0];
            end
        end else begin
            if (tgt_dn[DUTY_W] || (tgt_dn < MIN_W)) begin
                duty_nx = MIN_W[DUTY_W-1:0];
                dir_nx  = 1'b1;
            end else begin
                duty_nx = tgt_dn[DUTY_W-1:0];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            v_r        <= '0;
            i_r        <= '0;
            p_now      <= '0;
            p_prev     <= '0;
            prev_valid <= 1'b0;
            duty_q     <= INIT_D;
            dir_q      <= 1'b1;
            upd_q      <= 1'b0;
        end else begin
            upd_q <= 1'b0;
            if (!en) begin
                // Abandon the iteration; duty, dir and p_prev are held, and the
                // next run starts without a valid reference power.
                prev_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: cnt <= SETTLE_LD;
                    SETTLE: begin
                        if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    end
                    SAMPLE: begin
                        if (sample_valid) begin
                            v_r <= v_in;
                            i_r <= i_in;
                        end
                    end
                    CALC: p_now <= p_mult;
                    DECIDE: begin
                        duty_q     <= duty_nx;
                        dir_q      <= dir_nx;
                        p_prev     <= p_now;
                        prev_valid <= 1'b1;
                        upd_q      <= 1'b1;
                        cnt        <= SETTLE_LD;
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end

    assign duty  = duty_q;
    assign dir   = dir_q;
    assign p_out = p_prev;
    assign upd   = upd_q;

endmodule : mppt_po_ctrl

// File: tb/tb_mppt_po_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mppt_po_ctrl
// Directed self-checking bench for mppt_po_ctrl with default parameters
// (DUTY_INIT=128, limits 5..250, STEP=2, SETTLE_CYC=3).
// ---------------------------------------------------------------------------
module tb_mppt_po_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sample_req;
    logic        sample_valid;
    logic [5:0]  v_in, i_in;
    logic [7:0]  duty;
    logic        dir;
    logic [11:0] p_out;
    logic        upd;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mppt_po_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_req   (sample_req),
        .sample_valid (sample_valid),
        .v_in         (v_in),
        .i_in         (i_in),
        .duty         (duty),
        .dir          (dir),
        .p_out        (p_out),
        .upd          (upd),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One active edge, then settle at the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req();
        for (int n = 0; n < 40 && !sample_req; n++) tick();
        check("sample_req_timeout", sample_req, 1);
    endtask

    task automatic give_sample(input logic [5:0] v, input logic [5:0] i);
        v_in         = v;
        i_in         = i;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // Full iteration; returns in the cycle where upd must be high.
    task automatic iterate(input logic [5:0] v, input logic [5:0] i);
        wait_req();
        give_sample(v, i);
        tick();
        tick();
        check("upd_pulse", upd, 1);
    endtask

    initial begin
        rst_n        = 1'b0;
        en           = 1'b0;
        sample_valid = 1'b0;
        v_in         = '0;
        i_in         = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_duty", duty, 128);
        check("rst_dir", dir, 1);
        check("rst_p_out", p_out, 0);
        check("rst_busy", busy, 0);
        check("rst_upd", upd, 0);
        check("rst_req", sample_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        check("idle_en0_busy", busy, 0);
        check("idle_en0_req", sample_req, 0);

        // ---------------- first iteration ----------------
        en = 1'b1;
        tick();
        check("settle_busy", busy, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("settle_no_req", sample_req, 0);
        end
        tick();
        check("req_after_settle", sample_req, 1);
        give_sample(6'd10, 6'd10);
        check("req_drop_on_accept", sample_req, 0);
        check("upd_k", upd, 0);
        tick();
        check("upd_k1", upd, 0);
        check("p_out_k1_old", p_out, 0);
        tick();
        check("upd_k2", upd, 1);
        check("it1_p_out", p_out, 100);
        check("it1_duty", duty, 130);
        check("it1_dir", dir, 1);
        tick();
        check("upd_single", upd, 0);

        // ---------------- power drop, then equal power ----------------
        iterate(6'd9, 6'd10);
        check("drop_p_out", p_out, 90);
        check("drop_dir", dir, 0);
        check("drop_duty", duty, 128);
        iterate(6'd9, 6'd10);
        check("eq_dir", dir, 0);
        check("eq_duty", duty, 126);

        // ---------------- lower clamp ----------------
        for (int k = 0; k < 60; k++) iterate(6'd9, 6'd10);
        check("pre_min_duty", duty, 6);
        check("pre_min_dir", dir, 0);
        iterate(6'd9, 6'd10);
        check("min_clamp_duty", duty, 5);
        check("min_clamp_dir", dir, 1);

        // ---------------- upper clamp ----------------
        for (int k = 0; k < 122; k++) iterate(6'd9, 6'd10);
        check("pre_max_duty", duty, 249);
        check("pre_max_dir", dir, 1);
        iterate(6'd10, 6'd10);
        check("max_clamp_duty", duty, 250);
        check("max_clamp_dir", dir, 0);
        check("max_p_out", p_out, 100);

        // ---------------- full scale ----------------
        iterate(6'd63, 6'd63);
        check("full_p_out", p_out, 3969);
        check("full_duty", duty, 248);
        check("full_dir", dir, 0);

        // sample_valid during SETTLE is ignored
        v_in         = 6'd1;
        i_in         = 6'd1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("stray_valid_req", sample_req, 0);
        tick();
        check("stray_valid_p_out", p_out, 3969);

        // ---------------- abort during SAMPLE ----------------
        wait_req();
        v_in         = 6'd1;
        i_in         = 6'd1;
        sample_valid = 1'b1;
        en           = 1'b0;
        tick();
        sample_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_req", sample_req, 0);
        check("abort_duty", duty, 248);
        check("abort_dir", dir, 0);
        check("abort_p_out", p_out, 3969);
        check("abort_upd", upd, 0);
        tick();
        tick();
        check("abort_upd_later", upd, 0);

        // ---------------- re-enable with lower power ----------------
        en = 1'b1;
        iterate(6'd1, 6'd1);
        check("reen_p_out", p_out, 1);
        check("reen_dir", dir, 0);
        check("reen_duty", duty, 246);

        // ---------------- reset during CALC ----------------
        wait_req();
        give_sample(6'd5, 6'd5);
        check("calc_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_duty", duty, 128);
        check("arst_dir", dir, 1);
        check("arst_p_out", p_out, 0);
        check("arst_busy", busy, 0);
        check("arst_req", sample_req, 0);
        check("arst_upd", upd, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mppt_po_ctrl
